dcache_responder: RTL

Responder side of the CPU's data-memory interface: accepts the load/store requests the pipeline drives on `dcache_addr`/`dcache_we`/`dcache_re`/`dcache_din`, returns load data on `dcache_dout`, and raises `stall` while a request cannot complete. It is a direct-mapped, write-through, no-write-allocate cache with 4-word (128-bit) lines, backed by main memory over a valid/ready request channel and a valid-only response channel.

---
 rtl/dcache_pkg.sv | 41 ++++
 rtl/dcache_line_array.sv | 82 ++++++++
 rtl/dcache_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Types, constants and small helpers shared by the data-cache responder.
// Contents:
//   state_e      : controller states
//   LINE_W       : cache line width in bits (four 32-bit words)
//   OFFSET_W     : byte-offset bits within a line
//   MEM_ADDR_W   : line-address width on the memory channel
//   expand_mask  : places a 4-bit word byte-enable into a 16-bit line mask
//   select_word  : picks one 32-bit word out of a line
// ---------------------------------------------------------------------------
package dcache_pkg;

    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 4;
    localparam int MEM_ADDR_W = 32 - OFFSET_W;
    localparam int MASK_W     = LINE_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_REQ,
        ST_FILL_WAIT,
        ST_WRITE_REQ,
        ST_RESP
    } state_e;

    // Shift the word's byte enables into the lane selected by the word offset.
    function automatic logic [MASK_W-1:0] expand_mask(input logic [3:0] we,
                                                      input logic [1:0] word_off);
        logic [MASK_W-1:0] mask;
        mask = {12'h000, we} << {word_off, 2'b00};
        return mask;
    endfunction

    function automatic logic [WORD_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                      input logic [1:0]        word_off);
        return line[{word_off, 5'b00000} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// ---------------------------------------------------------------------------
// dcache_line_array
// Valid/tag/data storage for a direct-mapped cache.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (clears valid)
//   rd_index            : combinational read index
//   rd_valid/rd_tag     : valid bit and tag of the indexed line
//   rd_line             : data of the indexed line
//   wr_en               : write strobe
//   wr_fill             : write is a line fill (also sets tag and valid)
//   wr_index, wr_tag    : write location and tag (tag used on fills only)
//   wr_mask, wr_line    : per-byte enable and write data (fill = all ones)
// ---------------------------------------------------------------------------
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter  int LINES   = 64,
    localparam int INDEX_W = $clog2(LINES),
    localparam int TAG_W   = MEM_ADDR_W - INDEX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic               wr_fill,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [MASK_W-1:0]  wr_mask,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];
    logic [LINE_W-1:0] line_d;

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    // NOTE: every variable gets its default before any branch so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (wr_en && wr_fill) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Byte-merge the write into the current contents of the target line.
    always_comb begin
        line_d = data_q[wr_index];
        for (int b = 0; b < MASK_W; b++) begin
            if (wr_mask[b]) begin
                line_d[8*b +: 8] = wr_line[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: tag and data storage is deliberately not reset; a clear valid bit
    // makes their contents irrelevant and keeps the arrays plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index] <= line_d;
            if (wr_fill) begin
                tag_q[wr_index] <= wr_tag;
            end
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// ---------------------------------------------------------------------------
// dcache_responder
// Direct-mapped, write-through, no-write-allocate data cache with 4-word
// lines, answering the CPU's load/store port and backed by main memory.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   dcache_addr/re/we/din      : CPU request (we nonzero = store, wins over re)
//   dcache_dout                : registered load data
//   stall                      : request not accepted this cycle
//   mem_req_valid/ready        : memory request handshake
//   mem_req_rw, mem_req_addr   : 1 = write / 0 = line read, line address
//   mem_req_data_valid/ready   : write-data handshake
//   mem_req_data_bits/mask     : replicated store word and byte mask
//   mem_resp_valid/data        : returning line (word 0 in [31:0])
// ---------------------------------------------------------------------------
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           dcache_addr,
    input  logic                  dcache_re,
    input  logic [3:0]            dcache_we,
    input  logic [WORD_W-1:0]     dcache_din,
    output logic [WORD_W-1:0]     dcache_dout,
    output logic                  stall,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [MEM_ADDR_W-1:0] mem_req_addr,
    output logic                  mem_req_data_valid,
    input  logic                  mem_req_data_ready,
    output logic [LINE_W-1:0]     mem_req_data_bits,
    output logic [MASK_W-1:0]     mem_req_data_mask,
    input  logic                  mem_resp_valid,
    input  logic [LINE_W-1:0]     mem_resp_data
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

    state_e                state_q, state_d;
    logic [MEM_ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [1:0]            word_off_q, word_off_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0]     wmask_q, wmask_d;
    logic                  is_load_q, is_load_d;
    logic                  req_done_q, req_done_d;
    logic                  data_done_q, data_done_d;
    logic [WORD_W-1:0]     dout_q, dout_d;

    logic [MEM_ADDR_W-1:0] cur_line_addr;
    logic [INDEX_W-1:0]    cur_index;
    logic [TAG_W-1:0]      cur_tag;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  is_store;

    logic                  wr_en;
    logic                  wr_fill;
    logic [MASK_W-1:0]     wr_mask;
    logic [LINE_W-1:0]     wr_line;

    logic                  addr_fire;
    logic                  data_fire;

    // Byte-in-word bits play no part in a word-granular cache.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^dcache_addr[1:0];

    // In IDLE the array is looked up with the live request; afterwards with
    // the captured one, so the fill write and the RESP read hit the same line.
    assign cur_line_addr = (state_q == ST_IDLE) ? dcache_addr[31:OFFSET_W] : line_addr_q;
    assign cur_index     = cur_line_addr[INDEX_W-1:0];
    assign cur_tag       = cur_line_addr[MEM_ADDR_W-1 -: TAG_W];
    assign hit           = rd_valid && (rd_tag == cur_tag);
    assign is_store      = |dcache_we;

    dcache_line_array #(
        .LINES (LINES)
    ) u_lines (
        .clk      (clk),
        .reset    (reset),
        .rd_index (cur_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_fill  (wr_fill),
        .wr_index (cur_index),
        .wr_tag   (cur_tag),
        .wr_mask  (wr_mask),
        .wr_line  (wr_line)
    );

    always_comb begin
        state_d            = state_q;
        line_addr_d        = line_addr_q;
        word_off_d         = word_off_q;
        wdata_d            = wdata_q;
        wmask_d            = wmask_q;
        is_load_d          = is_load_q;
        req_done_d         = req_done_q;
        data_done_d        = data_done_q;
        dout_d             = dout_q;
        stall              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_data_valid = 1'b0;
        wr_en              = 1'b0;
        wr_fill            = 1'b0;
        wr_mask            = '0;
        wr_line            = '0;
        addr_fire          = 1'b0;
        data_fire          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_store) begin
                    stall       = 1'b1;
                    line_addr_d = dcache_addr[31:OFFSET_W];
                    word_off_d  = dcache_addr[3:2];
                    wdata_d     = dcache_din;
                    wmask_d     = expand_mask(dcache_we, dcache_addr[3:2]);
                    is_load_d   = 1'b0;
                    req_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    // Write-through keeps a resident copy current; misses do not allocate.
                    if (hit) begin
                        wr_en   = 1'b1;
                        wr_mask = expand_mask(dcache_we, dcache_addr[3:2]);
                        wr_line = {4{dcache_din}};
                    end
                    state_d = ST_WRITE_REQ;
                end else if (dcache_re) begin
                    if (hit) begin
                        dout_d = select_word(rd_line, dcache_addr[3:2]);
                    end else begin
                        stall       = 1'b1;
                        line_addr_d = dcache_addr[31:OFFSET_W];
                        word_off_d  = dcache_addr[3:2];
                        is_load_d   = 1'b1;
                        state_d     = ST_FILL_REQ;
                    end
                end
            end

            ST_FILL_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_FILL_WAIT;
                end
            end

            ST_FILL_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    wr_en   = 1'b1;
                    wr_fill = 1'b1;
                    wr_mask = '1;
                    wr_line = mem_resp_data;
                    state_d = ST_RESP;
                end
            end

            ST_WRITE_REQ: begin
                stall              = 1'b1;
                mem_req_rw         = 1'b1;
                mem_req_valid      = !req_done_q;
                mem_req_data_valid = !data_done_q;
                addr_fire          = !req_done_q && mem_req_ready;
                data_fire          = !data_done_q && mem_req_data_ready;
                // Each channel retires independently; the sticky flag keeps a
                // finished channel quiet while the other one is still pending.
                req_done_d         = req_done_q || addr_fire;
                data_done_d        = data_done_q || data_fire;
                if (req_done_d && data_done_d) begin
                    req_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: begin
                // The CPU still holds the retiring request; it is not looked at again.
                if (is_load_q) begin
                    dout_d = select_word(rd_line, word_off_q);
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            line_addr_q <= '0;
            word_off_q  <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            is_load_q   <= 1'b0;
            req_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            word_off_q  <= word_off_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            is_load_q   <= is_load_d;
            req_done_q  <= req_done_d;
            data_done_q <= data_done_d;
            dout_q      <= dout_d;
        end
    end

    assign dcache_dout       = dout_q;
    assign mem_req_addr      = line_addr_q;
    assign mem_req_data_bits = {4{wdata_q}};
    assign mem_req_data_mask = wmask_q;

endmodule
